expr_stream_sched: RTL and testbench
====================================

Name: expr_stream_sched

Overview:
- Scheduler sharing one arithmetic-string checker between N_REQ byte-stream requesters.
- Grants one requester at a time (round-robin) and holds the grant for a whole string, delimited by req_last.
- Feeds the granted bytes into the embedded checker, then issues one result per string: pass/fail, requester id and length.
- Sits between the character sources and the result consumer in the string-recognition datapath.

Parameters:
N_REQ, 4, number of requesters
ID_W, 2, requester id width; equals clog2(N_REQ)
LEN_W, 8, string length counter width; the counter saturates
TIMEOUT, 16, stall cycles before abort; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, synchronous, active-low
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester ASCII byte; requester i uses bits [8i+7:8i]
req_last  in  N_REQ  marks the final byte of the current string
req_ready  out  N_REQ  per-requester accept; one-hot or zero
res_valid  out  1  one-cycle result pulse
res_ok  out  1  string matched the grammar
res_id  out  ID_W  requester the result belongs to
res_len  out  LEN_W  bytes accepted, saturating
res_timeout  out  1  string aborted by the watchdog
busy  out  1  high in RUN and DONE

Behaviour:
- Reset: one clock edge with clr=0 clears state to IDLE and the rr pointer to N_REQ-1, so the first grant goes to requester 0. All outputs are 0 and the checker returns to C_START. An in-flight string is dropped with no result.
- Grammar: D([+*]D)*.
  - D is one byte in 48..57 ('0'..'9').
  - Operators are 42 ('*') and 43 ('+').
  - Every other byte is illegal.
  - The empty string is impossible because each string has at least one byte (the one with last).
- Checker states: C_START, C_NUM, C_OP, C_ERR.
  - C_START: digit -> C_NUM; else -> C_ERR.
  - C_NUM: operator -> C_OP; else -> C_ERR.
  - C_OP: digit -> C_NUM; else -> C_ERR.
  - C_ERR is sticky until the string ends.
- Scheduler states: IDLE, RUN, DONE.
  - IDLE: if any req_valid is high, choose the first set bit searching from rr+1 with wrap. Latch it as grant, go to RUN next cycle. Arbitration takes 1 cycle; req_ready is 0 in IDLE.
  - RUN: req_ready[grant]=1, combinational from state. A transfer is req_valid[grant]&req_ready[grant].
  - On each transfer the checker steps and the length counter increments, saturating at 2^LEN_W-1.
  - Transfer with req_last -> DONE.
  - Other requesters' valid is ignored and they are never stalled-out mid-string.
  - DONE: res_valid=1 for exactly this cycle, with res_id=grant and res_len=count.
  - In DONE, res_ok=1 iff the checker state after the last byte is C_NUM.
  - In DONE, rr<=grant, counter and checker clear, next state is IDLE.
- Throughput: a string of L bytes with no stalls occupies L+2 cycles.
- Requests raised during RUN or DONE wait until IDLE; no preemption.
- Simultaneous requests in IDLE: the rr search decides; the same requester never wins twice while another is waiting.
- res_* outputs hold their last values when res_valid=0; only res_valid is qualified.
- clr low during RUN: string aborted, no res_valid, next grant goes to requester 0.

Optional Feature:
- Macro: STR_TIMEOUT_EN.
- When defined:
  - A stall counter clears on every transfer and increments each RUN cycle without one.
  - On reaching TIMEOUT it forces DONE with res_ok=0, res_timeout=1 and res_len=bytes so far.
  - The requester's remaining bytes are then seen as a new string.
- When undefined: RUN waits indefinitely and res_timeout is tied to 0.

Decomposition:
- Package expr_sched_pkg holds:
  - the scheduler state enum (IDLE/RUN/DONE) and checker state enum;
  - ASCII constants CH_0=48, CH_9=57, CH_MUL=42, CH_ADD=43.
- Sub-module expr_checker: byte in, step enable, clear and state out. It is the pure grammar FSM, instantiated once.

Test Plan:
- Requester 0 sends "3", "+", "4" with last on "4". Required: res_valid in cycle 5 after the first valid, res_ok=1, res_id=0, res_len=3.
- Requester 2 sends "3", "+", "+", "4". Required: res_ok=0, res_len=4, and requester 2 remains granted through the illegal byte.
- Requesters 1 and 3 valid simultaneously from reset. Required: grant 1 first, then 3. With all 4 continuously valid, res_id sequence is 0,1,2,3,0.
- Single "+" with last. Required: res_ok=0, res_len=1. Single "7" with last: res_ok=1.
- clr=0 for one cycle mid-string on requester 1. Required: no res_valid, all req_ready=0 next cycle, next grant goes to requester 0 if valid.
- With STR_TIMEOUT_EN and TIMEOUT=16: requester 0 sends "5" then holds valid low. Required: res_valid 16 cycles after the transfer, res_timeout=1, res_ok=0, res_len=1.

Source files
------------

// File: rtl/expr_sched_pkg.sv
// Shared types and ASCII constants for the expression stream scheduler.
// Shared by expr_checker and expr_stream_sched.
package expr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        C_START = 2'd0,
        C_NUM   = 2'd1,
        C_OP    = 2'd2,
        C_ERR   = 2'd3
    } chk_state_e;

    localparam logic [7:0] CH_0   = 8'd48;
    localparam logic [7:0] CH_9   = 8'd57;
    localparam logic [7:0] CH_MUL = 8'd42;
    localparam logic [7:0] CH_ADD = 8'd43;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] b);
        return (b == CH_MUL) || (b == CH_ADD);
    endfunction

endpackage

// File: rtl/expr_checker.sv
// Grammar recogniser for D([+*]D)*: one byte per step, C_ERR sticky until clear.
module expr_checker
    import expr_sched_pkg::*;
(
    input  logic       clk,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic [7:0] data_i,
    output logic [1:0] state_o
);

    chk_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (step_i) begin
            unique case (state_q)
                C_START, C_OP: state_d = is_digit(data_i) ? C_NUM : C_ERR;
                C_NUM:         state_d = is_op(data_i)    ? C_OP  : C_ERR;
                default:       state_d = C_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) state_q <= C_START;
        else         state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/expr_stream_sched.sv
// Round-robin scheduler sharing one expression checker among N_REQ byte streams.
// Optional stall watchdog enabled by defining STR_TIMEOUT_EN.
module expr_stream_sched
    import expr_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic               res_ok,
    output logic [ID_W-1:0]    res_id,
    output logic [LEN_W-1:0]   res_len,
    output logic               res_timeout,
    output logic               busy
);

    if (ID_W != $clog2(N_REQ) || TIMEOUT < 2) begin : g_param_check
        $error("expr_stream_sched: inconsistent ID_W/N_REQ or TIMEOUT < 2");
    end

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  rr_q, rr_d, grant_q, grant_d, pick, arb_idx;
    logic [LEN_W-1:0] len_q, len_d;
    logic             hold_ok_q, hold_ok_d;
    logic [ID_W-1:0]  hold_id_q, hold_id_d;
    logic [LEN_W-1:0] hold_len_q, hold_len_d;
    logic             found, xfer, done, tmo_now, ok_now;
    logic [7:0]       cur_byte;
    logic [1:0]       chk_state;

    assign done     = (state_q == DONE);
    assign cur_byte = req_data[{grant_q, 3'b000} +: 8];
    assign xfer     = (state_q == RUN) && req_valid[grant_q];
    assign busy     = (state_q != IDLE);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == RUN) && (grant_q == ID_W'(gi));
    end

    // First valid requester after rr_q, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        arb_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = ID_W'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid[arb_idx]) begin
                found = 1'b1;
                pick  = arb_idx;
            end
        end
    end

    expr_checker u_checker (
        .clk     (clk),
        .clear_i (!clr || done),
        .step_i  (xfer),
        .data_i  (cur_byte),
        .state_o (chk_state)
    );

`ifdef STR_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               tmo_q, tmo_d, hold_tmo_q, hold_tmo_d;
    assign tmo_now     = tmo_q;
    assign res_timeout = done ? tmo_q : hold_tmo_q;
`else
    assign tmo_now     = 1'b0;
    assign res_timeout = 1'b0;
`endif

    assign ok_now    = (chk_state == C_NUM) && !tmo_now;
    assign res_valid = done;
    assign res_ok    = done ? ok_now  : hold_ok_q;
    assign res_id    = done ? grant_q : hold_id_q;
    assign res_len   = done ? len_q   : hold_len_q;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        len_d      = len_q;
        hold_ok_d  = hold_ok_q;
        hold_id_d  = hold_id_q;
        hold_len_d = hold_len_q;
`ifdef STR_TIMEOUT_EN
        stall_d    = '0;
        tmo_d      = tmo_q;
        hold_tmo_d = hold_tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (len_q != '1) len_d = len_q + LEN_W'(1);
                    if (req_last[grant_q]) state_d = DONE;
                end
`ifdef STR_TIMEOUT_EN
                // stall_q counts cycles since the last accepted byte (or RUN entry).
                if (xfer) begin
                    stall_d = STALL_W'(1);
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_d == STALL_W'(TIMEOUT)) begin
                        state_d = DONE;
                        tmo_d   = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                hold_ok_d  = ok_now;
                hold_id_d  = grant_q;
                hold_len_d = len_q;
`ifdef STR_TIMEOUT_EN
                hold_tmo_d = tmo_q;
                tmo_d      = 1'b0;
`endif
                rr_d    = grant_q;
                len_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= IDLE;
            rr_q       <= ID_W'(N_REQ - 1);
            grant_q    <= '0;
            len_q      <= '0;
            hold_ok_q  <= 1'b0;
            hold_id_q  <= '0;
            hold_len_q <= '0;
`ifdef STR_TIMEOUT_EN
            stall_q    <= '0;
            tmo_q      <= 1'b0;
            hold_tmo_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            hold_ok_q  <= hold_ok_d;
            hold_id_q  <= hold_id_d;
            hold_len_q <= hold_len_d;
`ifdef STR_TIMEOUT_EN
            stall_q    <= stall_d;
            tmo_q      <= tmo_d;
            hold_tmo_q <= hold_tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_expr_stream_sched.sv
// Self-checking bench for expr_stream_sched: directed scenarios plus random strings
// scored against a queue-based model of sources, grammar and round-robin order.
module tb_expr_stream_sched;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic               clk = 1'b0;
    logic               clr;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               res_valid, res_ok, res_timeout, busy;
    logic [ID_W-1:0]    res_id;
    logic [LEN_W-1:0]   res_len;

    always #5 clk = ~clk;

    expr_stream_sched #(
        .N_REQ(N_REQ), .ID_W(ID_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_ok(res_ok), .res_id(res_id),
        .res_len(res_len), .res_timeout(res_timeout), .busy(busy)
    );

    typedef struct {
        logic ok;
        int   len;
        logic tmo;
    } exp_t;

    logic [8:0]       src_q [N_REQ][$];   // {last, byte} still to be offered
    exp_t             exp_q [N_REQ][$];   // results still owed per requester
    logic [N_REQ-1:0] mid;
    int               cur, rr_model, cyc, res_cyc, prev_res_cyc, xfer_cyc;
    int               checks, failures;
    logic             spacing_en, stall_en;
    logic             hold_ok, hold_tmo;
    int               hold_id, hold_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic gram_ok(input logic [7:0] bq[$]);
        logic ok;
        ok = (bq.size() % 2) == 1;
        for (int k = 0; k < bq.size(); k++) begin
            if (k % 2 == 0) begin
                if (!(bq[k] >= 8'd48 && bq[k] <= 8'd57)) ok = 1'b0;
            end else begin
                if (!(bq[k] == 8'd42 || bq[k] == 8'd43)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < N_REQ; i++) n += src_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic load_bytes(input int id, input logic [7:0] bq[$]);
        exp_t e;
        for (int k = 0; k < bq.size(); k++)
            src_q[id].push_back({(k == bq.size() - 1) ? 1'b1 : 1'b0, bq[k]});
        e.ok  = gram_ok(bq);
        e.len = bq.size();
        e.tmo = 1'b0;
        exp_q[id].push_back(e);
    endtask

    task automatic load_str(input int id, input string s);
        logic [7:0] bq[$];
        for (int k = 0; k < s.len(); k++) bq.push_back(s[k]);
        load_bytes(id, bq);
    endtask

    task automatic load_rand(input int id);
        logic [7:0] bq[$];
        int         n;
        logic       good;
        n    = $urandom_range(1, 9);
        good = 1'($urandom_range(0, 1));
        for (int k = 0; k < n; k++) begin
            if (good) begin
                if (k % 2 == 0) bq.push_back(8'(48 + $urandom_range(0, 9)));
                else            bq.push_back($urandom_range(0, 1) ? 8'd42 : 8'd43);
            end else begin
                case ($urandom_range(0, 3))
                    0, 1:    bq.push_back(8'(48 + $urandom_range(0, 9)));
                    2:       bq.push_back($urandom_range(0, 1) ? 8'd42 : 8'd43);
                    default: bq.push_back(8'($urandom));
                endcase
            end
        end
        load_bytes(id, bq);
    endtask

    task automatic load_long(input int id, input int n);
        logic [7:0] bq[$];
        for (int k = 0; k < n; k++) bq.push_back((k % 2 == 0) ? 8'd49 : 8'd43);
        load_bytes(id, bq);
    endtask

    task automatic check_outputs();
        int   id, idx, pend;
        logic hit;
        exp_t e;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
        chk("busy", busy, (req_ready != '0) || res_valid);
        if (cur >= 0 && !res_valid) chk("held_grant", req_ready, 1 << cur);
        if (res_valid) begin
            pend = 0;
            for (int i = 0; i < N_REQ; i++) pend += exp_q[i].size();
            if (pend == 0) begin
                chk("unexpected_res", res_valid, 0);
            end else begin
                // next requester after the previous winner that still owes a string
                id  = rr_model;
                hit = 1'b0;
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = (rr_model + k) % N_REQ;
                    if (!hit && exp_q[idx].size() > 0) begin
                        id  = idx;
                        hit = 1'b1;
                    end
                end
                e = exp_q[id].pop_front();
                chk("res_id", res_id, id);
                chk("res_ok", res_ok, e.ok);
                chk("res_len", res_len, (e.len > LEN_MAX) ? LEN_MAX : e.len);
                chk("res_timeout", res_timeout, e.tmo);
                if (spacing_en && prev_res_cyc >= 0) chk("spacing", cyc - prev_res_cyc, e.len + 2);
                $display("res id=%0d ok=%0b len=%0d tmo=%0b cycle=%0d", res_id, res_ok, res_len, res_timeout, cyc);
                rr_model     = id;
                mid[id]      = 1'b0;
                cur          = -1;
                hold_id      = id;
                hold_ok      = e.ok;
                hold_len     = (e.len > LEN_MAX) ? LEN_MAX : e.len;
                hold_tmo     = e.tmo;
                prev_res_cyc = cyc;
                res_cyc      = cyc;
            end
        end else begin
            chk("hold_id", res_id, hold_id);
            chk("hold_ok", res_ok, hold_ok);
            chk("hold_len", res_len, hold_len);
            chk("hold_tmo", res_timeout, hold_tmo);
        end
    endtask

    task automatic cycle();
        logic [N_REQ-1:0] v, x;
        logic [8:0]       b;
        @(negedge clk);
        cyc++;
        check_outputs();
        v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i]        = 1'($urandom);
            if (src_q[i].size() > 0 && !(stall_en && mid[i] && $urandom_range(0, 3) == 0)) begin
                v[i]               = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end
        end
        req_valid = v;
        x = v & req_ready;
        for (int i = 0; i < N_REQ; i++) begin
            if (x[i]) begin
                b        = src_q[i].pop_front();
                mid[i]   = !b[8];
                cur      = b[8] ? -1 : i;
                xfer_cyc = cyc;
            end
        end
    endtask

    task automatic run(input int max_cyc);
        int k;
        k = 0;
        while (pending() > 0 && k < max_cyc) begin
            cycle();
            k++;
        end
        chk("run_drained", pending(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        clr       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        cyc++;
        clr = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        mid          = '0;
        cur          = -1;
        rr_model     = N_REQ - 1;
        hold_id      = 0;
        hold_ok      = 1'b0;
        hold_len     = 0;
        hold_tmo     = 1'b0;
        prev_res_cyc = -1;
        chk("rst_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_ok", res_ok, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_res_timeout", res_timeout, 0);
    endtask

    initial begin
        int n0;
        exp_t te;
        checks = 0; failures = 0; cyc = 0; res_cyc = -1; xfer_cyc = -1;
        spacing_en = 1'b0; stall_en = 1'b0;
        clr = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // requesters 1 and 3 together straight out of reset: 1 wins, then 3
        spacing_en = 1'b1;
        load_str(1, "1");
        load_str(3, "2+2");
        run(50);

        // all four valid: 0,1,2,3,0
        prev_res_cyc = -1;
        load_str(0, "1+1");
        load_str(0, "9");
        load_str(1, "2");
        load_str(2, "3*3*3");
        load_str(3, "4+5");
        run(100);

        // "3+4" on requester 0: result in the 5th cycle after first valid
        prev_res_cyc = -1;
        n0 = cyc + 1;
        load_str(0, "3+4");
        run(50);
        chk("first_latency", res_cyc - n0 + 1, 5);

        // illegal double operator, grant held through it
        load_str(2, "3++4");
        run(50);

        // single-byte strings
        load_str(3, "+");
        load_str(0, "7");
        run(50);

        // saturating length
        spacing_en = 1'b0;
        load_long(2, 261);
        load_long(1, 255);
        load_long(3, 256);
        run(1200);

        // clr mid-string on requester 1
        load_str(1, "1+2+3+4");
        repeat (3) cycle();
        do_reset();
        load_str(0, "8");
        load_str(1, "6");
        run(50);

        // random strings with mid-string stalls
        stall_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 1)) begin
                    for (int s = 0; s < $urandom_range(1, 3); s++) load_rand(i);
                end
            end
            run(2000);
        end
        stall_en = 1'b0;

`ifdef STR_TIMEOUT_EN
        // "5" then silence: watchdog result TIMEOUT cycles after the transfer
        te.ok  = 1'b0;
        te.len = 1;
        te.tmo = 1'b1;
        src_q[0].push_back({1'b0, 8'd53});
        exp_q[0].push_back(te);
        run(100);
        chk("tmo_latency", res_cyc - xfer_cyc, TIMEOUT);
`else
        te.len = 0;
`endif

        repeat (2) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
